// File: rtl/vector_reduce_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : vector_reduce_sequencer_if
// Description : Beat-input / frame-result handshake bundle for the vector
//               reduction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface vector_reduce_sequencer_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32
);
    logic                             in_valid;
    logic                             in_ready;
    logic [N-1:0][DATA_WIDTH-1:0]     in_vector;
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_WIDTH-1:0]            out_sum;
    logic [7:0]                       out_frame_id;

    modport master (
        output in_valid, in_vector, out_ready,
        input  in_ready, out_valid, out_sum, out_frame_id
    );

    modport slave (
        input  in_valid, in_vector, out_ready,
        output in_ready, out_valid, out_sum, out_frame_id
    );
endinterface
`default_nettype wire

// File: rtl/vector_reduce_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vector_reduce_sequencer
// Description : Reduces multi-beat N-element vector frames to one scalar sum
//               through a shared adder tree. Define REDUCE_SEQ_TREE_PIPE_EN to
//               register the tree sum ahead of the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================

module adderTree #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic [N-1:0][DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0]        o_sum
);
    always_comb begin
        o_sum = '0;
        for (int i = 0; i < N; i++) begin
            o_sum = o_sum + i_data[i];
        end
    end
endmodule

module vector_reduce_sequencer #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16,
    localparam int BW        = $clog2(MAX_BEATS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BW-1:0]            cfg_beats,
    output logic                     busy,
    vector_reduce_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_FLUSH = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [BW-1:0] c_max_beats = BW'(MAX_BEATS);
    localparam logic [BW-1:0] c_one       = BW'(1);
`ifdef REDUCE_SEQ_TREE_PIPE_EN
    localparam state_t        c_done_state = S_FLUSH;
`else
    localparam state_t        c_done_state = S_OUT;
`endif

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_accept;
    logic                  w_out_fire;
    logic [BW-1:0]         w_beats_new;
    logic [BW-1:0]         w_cnt_inc;
    logic [DATA_WIDTH-1:0] w_tree_sum;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [BW-1:0]         r_cnt;
    logic [BW-1:0]         r_beats;
    logic [7:0]            r_frame_id;

    adderTree #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tree (
        .i_data (bus.in_vector),
        .o_sum  (w_tree_sum)
    );

    // Zero means a single beat; oversize requests saturate at MAX_BEATS.
    assign w_beats_new = (cfg_beats == '0)         ? c_one :
                         (cfg_beats > c_max_beats) ? c_max_beats : cfg_beats;
    assign w_cnt_inc   = r_cnt + c_one;
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = (w_beats_new == c_one) ? c_done_state : S_ACC;
                end
            end
            S_ACC: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && (w_cnt_inc == r_beats)) begin
                    w_state_next = c_done_state;
                end
            end
            S_FLUSH: begin
                w_state_next = S_OUT;
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef REDUCE_SEQ_TREE_PIPE_EN
    logic [DATA_WIDTH-1:0] r_pipe_sum;
    logic                  r_pipe_vld;

    // The accumulator trails the accepted beat by one cycle; FLUSH drains the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_sum <= '0;
            r_pipe_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_pipe_vld <= w_accept;
            if (w_accept) begin
                r_pipe_sum <= w_tree_sum;
            end
            if (w_accept && (r_state == S_IDLE)) begin
                r_acc <= '0;
            end else if (r_pipe_vld) begin
                r_acc <= r_acc + r_pipe_sum;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= (r_state == S_IDLE) ? w_tree_sum : (r_acc + w_tree_sum);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_beats    <= '0;
            r_frame_id <= '0;
        end else begin
            if (w_accept) begin
                if (r_state == S_IDLE) begin
                    r_beats <= w_beats_new;
                    r_cnt   <= c_one;
                end else begin
                    r_cnt   <= w_cnt_inc;
                end
            end
            if (w_out_fire) begin
                r_frame_id <= r_frame_id + 8'd1;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_sum      = r_acc;
    assign bus.out_frame_id = r_frame_id;
    assign busy             = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_vector_reduce_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_reduce_sequencer
// Description : Directed self-checking bench for vector_reduce_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_reduce_sequencer;
    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int MB  = 16;
    localparam int BW  = $clog2(MB + 1);
`ifdef REDUCE_SEQ_TREE_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] cfg_beats;
    logic          busy;
    int            n_checks = 0;
    int            n_fail   = 0;

    vector_reduce_sequencer_if #(.N(N), .DATA_WIDTH(DW)) bus ();

    vector_reduce_sequencer #(
        .N          (N),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_beats (cfg_beats),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Offers one beat starting at a negedge and returns at the negedge after it is taken.
    task automatic drive_beat(input logic [DW-1:0] v, input logic [BW-1:0] cfg, output bit ok);
        int n = 0;
        bus.in_vector = {N{v}};
        cfg_beats     = cfg;
        bus.in_valid  = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 50);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) lat = -1;
    endtask

    task automatic pulse_ready();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out_sum !== 32'd0) begin n_fail++; $display("FAIL reset_out_sum: got %h expected 0", bus.out_sum); end
        n_checks++; if (bus.out_frame_id !== 8'd0) begin n_fail++; $display("FAIL reset_frame_id: got %0d expected 0", bus.out_frame_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_single_beat();
        bit ok; int lat;
        drive_beat(32'd1, 5'd1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_accept: got timeout expected accept"); end
        wait_valid(lat);
        n_checks++; if (lat !== LAT - 1) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat + 1, LAT); end
        n_checks++; if (bus.out_sum !== 32'd8) begin n_fail++; $display("FAIL single_sum: got %0d expected 8", bus.out_sum); end
        n_checks++; if (bus.out_frame_id !== 8'd0) begin n_fail++; $display("FAIL single_frame_id: got %0d expected 0", bus.out_frame_id); end
        pulse_ready();
        n_checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_release: got busy=%b valid=%b expected 0 0", busy, bus.out_valid); end
    endtask

    task automatic test_four_beat_gaps();
        bit ok; int lat;
        for (int k = 0; k < 4; k++) begin
            // Later beats present cfg_beats=1 to show it is ignored mid-frame.
            drive_beat(DW'(k + 1), (k == 0) ? 5'd4 : 5'd1, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL four_accept%0d: got timeout expected accept", k); end
            if (k < 3) begin
                repeat (2) begin
                    @(negedge clk);
                    n_checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL four_busy%0d: got busy=%b valid=%b expected 1 0", k, busy, bus.out_valid); end
                end
            end
        end
        wait_valid(lat);
        n_checks++; if (lat !== LAT - 1) begin n_fail++; $display("FAIL four_latency: got %0d expected %0d", lat + 1, LAT); end
        n_checks++; if (bus.out_sum !== 32'd80) begin n_fail++; $display("FAIL four_sum: got %0d expected 80", bus.out_sum); end
        n_checks++; if (bus.out_frame_id !== 8'd1) begin n_fail++; $display("FAIL four_frame_id: got %0d expected 1", bus.out_frame_id); end
        pulse_ready();
    endtask

    task automatic test_backpressure();
        bit ok; int lat;
        drive_beat(32'd3, 5'd1, ok);
        wait_valid(lat);
        n_checks++; if (lat < 0) begin n_fail++; $display("FAIL bp_first_valid: got timeout expected out_valid"); end
        bus.in_vector = {N{32'd5}};
        cfg_beats     = 5'd1;
        bus.in_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b expected 1", bus.out_valid); end
            n_checks++; if (bus.out_sum !== 32'd24 || bus.out_frame_id !== 8'd2) begin n_fail++; $display("FAIL bp_stable: got sum=%0d id=%0d expected 24 2", bus.out_sum, bus.out_frame_id); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
        end
        pulse_ready();
        n_checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle_gap: got ready=%b busy=%b valid=%b expected 1 0 0", bus.in_ready, busy, bus.out_valid); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_new_accept: got busy=%b expected 1", busy); end
        wait_valid(lat);
        n_checks++; if (lat !== LAT - 1) begin n_fail++; $display("FAIL bp_latency: got %0d expected %0d", lat + 1, LAT); end
        n_checks++; if (bus.out_sum !== 32'd40 || bus.out_frame_id !== 8'd3) begin n_fail++; $display("FAIL bp_second: got sum=%0d id=%0d expected 40 3", bus.out_sum, bus.out_frame_id); end
        pulse_ready();
    endtask

    task automatic test_wrap();
        bit ok; int lat;
        drive_beat(32'h2000_0000, 5'd1, ok);
        wait_valid(lat);
        n_checks++; if (lat < 0 || bus.out_sum !== 32'd0 || bus.out_frame_id !== 8'd4) begin n_fail++; $display("FAIL wrap_zero: got sum=%h id=%0d lat=%0d expected 0 4", bus.out_sum, bus.out_frame_id, lat); end
        pulse_ready();
        drive_beat(32'hFFFF_FFFF, 5'd2, ok);
        drive_beat(32'hFFFF_FFFF, 5'd2, ok);
        wait_valid(lat);
        n_checks++; if (lat !== LAT - 1 || bus.out_sum !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL wrap_neg: got sum=%h lat=%0d expected fffffff0", bus.out_sum, lat); end
        n_checks++; if (bus.out_frame_id !== 8'd5) begin n_fail++; $display("FAIL wrap_frame_id: got %0d expected 5", bus.out_frame_id); end
        pulse_ready();
    endtask

    task automatic test_reset_mid_frame();
        bit ok; int lat;
        drive_beat(32'd7, 5'd4, ok);
        drive_beat(32'd7, 5'd4, ok);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctl: got valid=%b busy=%b expected 0 0", bus.out_valid, busy); end
        n_checks++; if (bus.out_sum !== 32'd0 || bus.out_frame_id !== 8'd0) begin n_fail++; $display("FAIL mid_reset_data: got sum=%0d id=%0d expected 0 0", bus.out_sum, bus.out_frame_id); end
        reset = 1'b0;
        @(negedge clk);
        drive_beat(32'd1, 5'd2, ok);
        drive_beat(32'd1, 5'd2, ok);
        wait_valid(lat);
        n_checks++; if (lat !== LAT - 1 || bus.out_sum !== 32'd16) begin n_fail++; $display("FAIL mid_next_sum: got sum=%0d lat=%0d expected 16", bus.out_sum, lat); end
        n_checks++; if (bus.out_frame_id !== 8'd0) begin n_fail++; $display("FAIL mid_next_id: got %0d expected 0", bus.out_frame_id); end
        pulse_ready();
    endtask

    task automatic test_beat_edges();
        bit ok; int lat;
        drive_beat(32'd2, 5'd0, ok);
        wait_valid(lat);
        n_checks++; if (lat !== LAT - 1 || bus.out_sum !== 32'd16) begin n_fail++; $display("FAIL zero_beats: got sum=%0d lat=%0d expected 16", bus.out_sum, lat); end
        n_checks++; if (bus.out_frame_id !== 8'd1) begin n_fail++; $display("FAIL zero_beats_id: got %0d expected 1", bus.out_frame_id); end
        pulse_ready();
        for (int b = 0; b < 15; b++) drive_beat(32'd1, (b == 0) ? 5'd17 : 5'd0, ok);
        repeat (2) @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL clamp_early: got valid=%b ready=%b expected 0 1", bus.out_valid, bus.in_ready); end
        drive_beat(32'd1, 5'd0, ok);
        wait_valid(lat);
        n_checks++; if (lat !== LAT - 1 || bus.out_sum !== 32'd128) begin n_fail++; $display("FAIL clamp_sum: got sum=%0d lat=%0d expected 128", bus.out_sum, lat); end
        n_checks++; if (bus.out_frame_id !== 8'd2) begin n_fail++; $display("FAIL clamp_id: got %0d expected 2", bus.out_frame_id); end
        pulse_ready();
        for (int f = 3; f < 256; f++) begin
            drive_beat(DW'(f), 5'd1, ok);
            wait_valid(lat);
            if (f == 255) begin
                n_checks++; if (bus.out_frame_id !== 8'd255 || bus.out_sum !== 32'd2040) begin n_fail++; $display("FAIL id_255: got id=%0d sum=%0d expected 255 2040", bus.out_frame_id, bus.out_sum); end
            end
            pulse_ready();
        end
        drive_beat(32'd4, 5'd1, ok);
        wait_valid(lat);
        n_checks++; if (lat < 0 || bus.out_frame_id !== 8'd0 || bus.out_sum !== 32'd32) begin n_fail++; $display("FAIL id_wrap: got id=%0d sum=%0d expected 0 32", bus.out_frame_id, bus.out_sum); end
        pulse_ready();
    endtask

    initial begin
        reset         = 1'b1;
        cfg_beats     = '0;
        bus.in_valid  = 1'b0;
        bus.in_vector = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_beat();
        test_four_beat_gaps();
        test_backpressure();
        test_wrap();
        test_reset_mid_frame();
        test_beat_edges();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
